// File: rtl/lop_hazard_ctlr.sv
// Issue and hazard control for the shared long-op unit (int div/rem, FP div/sqrt):
// starts the unit from E, tracks its one pending destination, stalls D and arbitrates the W write port.
module lop_hazard_ctlr #(
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_D_rs1_index,
    input  logic [4:0] i_D_rs2_index,
    input  logic [4:0] i_D_rs3_index,
    input  logic [2:0] i_D_ftype,
    input  logic [4:0] i_D_rd_index,
    input  logic       i_D_wb_en,
    input  logic       i_D_wb_en_f,
    input  logic       i_D_lop,
    input  logic       i_E_lop,
    input  logic [4:0] i_E_rd_index,
    input  logic       i_E_rd_f,
    input  logic       i_E_load,
    input  logic       i_E_load_f,
    input  logic       i_E_flush,
    input  logic       i_lop_done,
    input  logic       i_W_wb_en,
    input  logic       i_W_wb_en_f,
    output logic       o_lop_start,
    output logic       o_D_stall,
    output logic       o_freeze,
    output logic       o_W_bubble,
    output logic       o_lop_wb_grant,
    output logic [4:0] o_lop_wb_rd,
    output logic       o_lop_wb_f,
    output logic       o_lop_busy,
    output logic       o_lop_timeout,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        WB_ARB = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       pend_rd_q;
    logic             pend_f_q;
    logic             pend_v_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_inc;
    logic             timeout_q;

    logic             start_ok;
    logic             w_port_busy;
    logic             pend_live;
    logic [2:0][4:0]  src;
    logic             raw_hit, waw_hit, struct_hit, lu_int_hit, lu_fp_hit;

    assign start_ok    = i_E_lop & ~i_E_flush;
    assign w_port_busy = i_W_wb_en | i_W_wb_en_f;
    assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign src         = {i_D_rs3_index, i_D_rs2_index, i_D_rs1_index};

    always_comb begin
        state_d        = state_q;
        o_lop_start    = 1'b0;
        o_lop_wb_grant = 1'b0;
        o_freeze       = 1'b0;
        o_W_bubble     = 1'b0;
        case (state_q)
            IDLE: begin
                // The unit shares rst, so a start issued during reset would be lost.
                if (start_ok && !rst) begin
                    o_lop_start = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (i_lop_done) state_d = WB_ARB;
            end
            WB_ARB: begin
                if (!pend_v_q) begin
                    state_d = IDLE;
                end else if (w_port_busy) begin
                    o_freeze   = 1'b1;
                    o_W_bubble = 1'b1;
                end else begin
                    o_lop_wb_grant = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_rd_q <= 5'd0;
            pend_f_q  <= 1'b0;
            pend_v_q  <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (o_lop_start) begin
                pend_rd_q <= i_E_rd_index;
                pend_f_q  <= i_E_rd_f;
                // An integer x0 target is never written, so nothing needs to wait on it.
                pend_v_q  <= i_E_rd_f | (i_E_rd_index != 5'd0);
                cnt_q     <= '0;
            end else if (state_q == BUSY) begin
                if (!cnt_inc[CNT_W]) cnt_q <= cnt_inc[CNT_W-1:0];
                if (cnt_inc >= (CNT_W+1)'(MAX_CYCLES)) timeout_q <= 1'b1;
            end
            if (o_lop_wb_grant) pend_v_q <= 1'b0;
        end
    end

    // In the grant cycle the result is forwarded, so the pending entry no longer blocks D.
    assign pend_live = pend_v_q & ~o_lop_wb_grant;

    always_comb begin
        raw_hit    = 1'b0;
        lu_int_hit = 1'b0;
        lu_fp_hit  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            raw_hit    = raw_hit | (pend_live & (i_D_ftype[n] == pend_f_q) &
                         (src[n] == pend_rd_q) & (i_D_ftype[n] | (src[n] != 5'd0)));
            lu_int_hit = lu_int_hit | (~i_D_ftype[n] & (src[n] != 5'd0) &
                         (src[n] == i_E_rd_index));
            lu_fp_hit  = lu_fp_hit | (i_D_ftype[n] & (src[n] == i_E_rd_index));
        end
    end

    assign waw_hit    = pend_live & (i_D_rd_index == pend_rd_q) &
                        ((i_D_wb_en & ~pend_f_q & (pend_rd_q != 5'd0)) | (i_D_wb_en_f & pend_f_q));
    assign struct_hit = i_D_lop & (o_lop_busy | start_ok);

    assign o_D_stall  = raw_hit | waw_hit | struct_hit |
                        (i_E_load & ~i_E_flush & (i_E_rd_index != 5'd0) & lu_int_hit) |
                        (i_E_load_f & lu_fp_hit);

    assign o_lop_busy    = (state_q != IDLE);
    assign o_lop_timeout = timeout_q;
    assign o_lop_wb_rd   = o_lop_wb_grant ? pend_rd_q : 5'd0;
    assign o_lop_wb_f    = o_lop_wb_grant & pend_f_q;
    assign o_dbg_state   = state_q;

endmodule

// File: doc/lop_hazard_ctlr.md
Name: lop_hazard_ctlr

Overview:
- Issue/hazard controller for the shared multi-cycle long-op unit (integer div/rem, FP div/sqrt) in the 5-stage integer+FP pipeline.
- Starts the unit from E, scoreboards its single pending destination (int or FP file), and stalls D on RAW/WAW/structural and load-use hazards.
- Arbitrates the shared W-stage write port for the long-op result, freezing the pipeline and injecting a W bubble when the port is busy.

Parameters:
- MAX_CYCLES, 64, busy-cycle limit before o_lop_timeout is set.
- CNT_W, 7, busy counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_D_rs1_index / i_D_rs2_index / i_D_rs3_index  in  5 each  D-stage sources
- i_D_ftype  in  3  per-source FP select [0]=rs1 [1]=rs2 [2]=rs3; 1=FP file
- i_D_rd_index  in  5  D destination
- i_D_wb_en / i_D_wb_en_f  in  1 each  D writes int / FP file
- i_D_lop  in  1  D instruction is a long op
- i_E_lop  in  1  E instruction is a long op
- i_E_rd_index  in  5  E destination
- i_E_rd_f  in  1  E long-op destination is FP
- i_E_load  in  1  E is an integer load
- i_E_load_f  in  1  E is an FP load
- i_E_flush  in  1  E instruction killed this cycle
- i_lop_done  in  1  unit result valid; pulse
- i_W_wb_en / i_W_wb_en_f  in  1 each  W uses write port this cycle
- o_lop_start  out  1  unit start pulse
- o_D_stall  out  1  hold F/D, bubble into E
- o_freeze  out  1  hold F/D/E/M
- o_W_bubble  out  1  turn M->W transfer into bubble
- o_lop_wb_grant  out  1  write long-op result via W port this cycle
- o_lop_wb_rd  out  5  result destination
- o_lop_wb_f  out  1  1 = FP file
- o_lop_busy  out  1  op outstanding
- o_lop_timeout  out  1  sticky error

Behaviour:
- State machine: IDLE, BUSY, WB_ARB.
- IDLE:
  - If i_E_lop & !i_E_flush: o_lop_start=1 (combinational, same cycle).
  - Capture pend_rd, pend_f and set pend_v. pend_v stays 0 when !i_E_rd_f and i_E_rd_index==0; the op still runs.
  - Counter clears; go to BUSY.
- BUSY:
  - Counter +1 per cycle, saturating.
  - Reaching MAX_CYCLES sets o_lop_timeout; it clears only on rst.
  - i_lop_done -> WB_ARB.
  - i_lop_done arriving in IDLE is ignored.
- WB_ARB:
  - If !(i_W_wb_en | i_W_wb_en_f): o_lop_wb_grant=1 with pend_rd/pend_f, clear pend_v, go to IDLE.
  - Otherwise o_freeze=1 and o_W_bubble=1 for that cycle and stay in WB_ARB; the grant follows the next cycle.
  - If pend_v=0 (x0 target), go to IDLE with no grant and no freeze.
- o_lop_busy = (state != IDLE).
- o_D_stall is the OR of:
  - RAW: pend_v and any D source n with (ftype[n]==pend_f) and index==pend_rd.
  - WAW: pend_v and ((i_D_wb_en & !pend_f) | (i_D_wb_en_f & pend_f)) and i_D_rd_index==pend_rd.
  - Structural: i_D_lop & (o_lop_busy | (i_E_lop & !i_E_flush)).
  - Load-use: i_E_load & !i_E_flush & i_E_rd_index!=0 & int source match; or i_E_load_f & FP source match (f0 included). This lasts 1 cycle only.
  - Int-file compare to index 0 never stalls; FP index 0 is a real register.
- Same cycle as grant: pend_v already counts as cleared for the stall equation, so a D consumer proceeds and forwarding supplies the value.
- o_freeze overrides o_D_stall (both may be 1).
- Reset at any point: state IDLE, pend_v=0, counter=0, all outputs 0 including o_lop_timeout. The in-flight op is discarded and the unit is reset by the same rst.
- Flush while BUSY/WB_ARB does not cancel the op; the long op is older than any flushed instruction.

Test Plan:
- Int div, E rd=x5, W idle at done: start at T, done at T+10 -> grant at T+11 with rd=5, f=0; o_lop_busy high T+1..T+11.
- D has add x6,x5,x1 during BUSY -> o_D_stall=1 every cycle until the grant cycle, 0 in the grant cycle. A D source of f5 with ftype=1 -> no stall.
- fdiv f0 done while i_W_wb_en=1 -> o_freeze=1 and o_W_bubble=1 one cycle; next cycle W idle -> grant rd=0, f=1.
- Int div to x0 -> start pulse; nothing stalls on x0; on done, no grant and return to IDLE.
- Long op in D while E starts a long op -> stall. Load x7 in E with D rs2=x7 -> single-cycle stall. i_E_flush=1 with i_E_lop -> no start, stays IDLE.
- MAX_CYCLES=64 with no done -> o_lop_timeout=1 after 64 busy cycles and stays set; rst mid-BUSY clears all outputs the next cycle.
